// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, operand typedefs and the operand-fetch S1 state
package core_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 32;
  localparam int INFO_WIDTH = 64;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]      word_t;

  // FRESH: operands flow straight from the regfile read port.
  // HELD: operands were captured because execute stalled.
  typedef enum logic {
    S1_FRESH = 1'b0,
    S1_HELD  = 1'b1
  } s1_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set/clear and hazard queries (OPFETCH_WB_BYPASS_EN)
import core_pkg::*;

module regfile_scoreboard #(
  parameter int REG_COUNT  = core_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] q_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] q_rs2_addr,
  input  logic [ADDR_WIDTH-1:0] q_rd_addr,
  output logic                  q_rs1_busy,
  output logic                  q_rs2_busy,
  output logic                  q_rd_busy
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_next;
  logic [REG_COUNT-1:0] busy_view;

  // Next busy vector: clear first so a same-address set wins; x0 is pinned idle.
  always_comb begin
    busy_next = busy;
    if (clr_en && clr_addr != '0) busy_next[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy register.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // Query view: with bypass, the register being written back this cycle already reads as free.
  always_comb begin
    busy_view = busy;
`ifdef OPFETCH_WB_BYPASS_EN
    if (clr_en) busy_view[clr_addr] = 1'b0;
`else
    busy_view = busy;
`endif
  end

  assign q_rs1_busy = busy_view[q_rs1_addr];
  assign q_rs2_busy = busy_view[q_rs2_addr];
  assign q_rd_busy  = busy_view[q_rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: hazard-checked issue, regfile read, held operands (OPFETCH_WB_BYPASS_EN)
import core_pkg::*;

module operand_fetch #(
  parameter int WIDTH      = core_pkg::WIDTH,
  parameter int REG_COUNT  = core_pkg::REG_COUNT,
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int INFO_WIDTH = core_pkg::INFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic                  id_rs1_use,
  input  logic                  id_rs2_use,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                  id_rd_we,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [INFO_WIDTH-1:0] id_info,
  output logic                  rs1_en,
  output logic                  rs2_en,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [WIDTH-1:0]      rs1_data,
  input  logic [WIDTH-1:0]      rs2_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [WIDTH-1:0]      ex_rs1_data,
  output logic [WIDTH-1:0]      ex_rs2_data,
  output logic                  ex_rd_we,
  output logic [ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [INFO_WIDTH-1:0] ex_info
);

  s1_state_t             state_q;
  s1_state_t             state_d;
  logic                  capture;
  logic                  ex_valid_q;
  logic                  ex_rd_we_q;
  logic [ADDR_WIDTH-1:0] ex_rd_addr_q;
  logic [INFO_WIDTH-1:0] ex_info_q;
  logic                  rs1_use_q;
  logic                  rs2_use_q;
  logic [WIDTH-1:0]      hold1_q;
  logic [WIDTH-1:0]      hold2_q;
  logic [ADDR_WIDTH-1:0] rs1_addr_q;
  logic [ADDR_WIDTH-1:0] rs2_addr_q;
  logic                  sb_rs1_busy;
  logic                  sb_rs2_busy;
  logic                  sb_rd_busy;
  logic                  haz_sb;
  logic                  haz_s1;
  logic                  accept;
  logic                  ex_fire;

  assign ex_fire = ex_valid_q && ex_ready;

  regfile_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (ex_fire && ex_rd_we_q),
    .set_addr   (ex_rd_addr_q),
    .clr_en     (wb_en),
    .clr_addr   (wb_addr),
    .q_rs1_addr (id_rs1_addr),
    .q_rs2_addr (id_rs2_addr),
    .q_rd_addr  (id_rd_addr),
    .q_rs1_busy (sb_rs1_busy),
    .q_rs2_busy (sb_rs2_busy),
    .q_rd_busy  (sb_rd_busy)
  );

  assign haz_sb = (id_rs1_use && sb_rs1_busy) ||
                  (id_rs2_use && sb_rs2_busy) ||
                  (id_rd_we   && sb_rd_busy);

  // The instruction sitting in S1 has not set its busy bit yet, so compare against it directly.
  always_comb begin
    haz_s1 = 1'b0;
    if (ex_valid_q && ex_rd_we_q && ex_rd_addr_q != '0) begin
      if (id_rs1_use && id_rs1_addr == ex_rd_addr_q) haz_s1 = 1'b1;
      if (id_rs2_use && id_rs2_addr == ex_rd_addr_q) haz_s1 = 1'b1;
      if (id_rd_we   && id_rd_addr  == ex_rd_addr_q) haz_s1 = 1'b1;
    end
  end

  assign id_ready = !rst && !flush && (!ex_valid_q || ex_ready) && !haz_sb && !haz_s1;
  assign accept   = id_valid && id_ready;

  assign rs1_en   = accept && id_rs1_use;
  assign rs2_en   = accept && id_rs2_use;
  assign rs1_addr = accept ? id_rs1_addr : rs1_addr_q;
  assign rs2_addr = accept ? id_rs2_addr : rs2_addr_q;

  // S1 next state: a stalled first cycle captures the read data; a handshake or flush frees it.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S1_FRESH: begin
        if (ex_valid_q && !ex_ready && !flush) begin
          state_d = S1_HELD;
          capture = 1'b1;
        end
      end
      S1_HELD: begin
        if (ex_fire || flush) state_d = S1_FRESH;
      end
      default: state_d = S1_FRESH;
    endcase
  end

  // S1 state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S1_FRESH;
    else     state_q <= state_d;
  end

  // S1 payload, hold registers and the last driven read addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_rd_we_q   <= 1'b0;
      ex_rd_addr_q <= '0;
      ex_info_q    <= '0;
      rs1_use_q    <= 1'b0;
      rs2_use_q    <= 1'b0;
      hold1_q      <= '0;
      hold2_q      <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
    end else begin
      if (accept) begin
        rs1_addr_q <= id_rs1_addr;
        rs2_addr_q <= id_rs2_addr;
      end
      if (flush) begin
        ex_valid_q <= 1'b0;
      end else if (accept) begin
        ex_valid_q   <= 1'b1;
        ex_rd_we_q   <= id_rd_we;
        ex_rd_addr_q <= id_rd_addr;
        ex_info_q    <= id_info;
        rs1_use_q    <= id_rs1_use;
        rs2_use_q    <= id_rs2_use;
      end else if (ex_fire) begin
        ex_valid_q <= 1'b0;
      end
      if (capture) begin
        hold1_q <= rs1_data;
        hold2_q <= rs2_data;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rd_we    = ex_rd_we_q;
  assign ex_rd_addr  = ex_rd_addr_q;
  assign ex_info     = ex_info_q;
  assign ex_rs1_data = (ex_valid_q && rs1_use_q) ? ((state_q == S1_HELD) ? hold1_q : rs1_data) : '0;
  assign ex_rs2_data = (ex_valid_q && rs2_use_q) ? ((state_q == S1_HELD) ? hold2_q : rs2_data) : '0;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized scoreboard bench for operand_fetch (OPFETCH_WB_BYPASS_EN aware)
module tb_operand_fetch;

  localparam int WIDTH      = 32;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int INFO_WIDTH = 64;
`ifdef OPFETCH_WB_BYPASS_EN
  localparam int WB_GAP = 0;
`else
  localparam int WB_GAP = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  id_valid = 1'b0;
  logic                  id_ready;
  logic                  id_rs1_use = 1'b0;
  logic                  id_rs2_use = 1'b0;
  logic [ADDR_WIDTH-1:0] id_rs1_addr = '0;
  logic [ADDR_WIDTH-1:0] id_rs2_addr = '0;
  logic                  id_rd_we = 1'b0;
  logic [ADDR_WIDTH-1:0] id_rd_addr = '0;
  logic [INFO_WIDTH-1:0] id_info = '0;
  logic                  rs1_en, rs2_en;
  logic [ADDR_WIDTH-1:0] rs1_addr, rs2_addr;
  logic [WIDTH-1:0]      rs1_data = '0;
  logic [WIDTH-1:0]      rs2_data = '0;
  logic                  wb_en = 1'b0;
  logic [ADDR_WIDTH-1:0] wb_addr = '0;
  logic [WIDTH-1:0]      wb_data = '0;
  logic                  ex_valid;
  logic                  ex_ready = 1'b1;
  logic [WIDTH-1:0]      ex_rs1_data, ex_rs2_data;
  logic                  ex_rd_we;
  logic [ADDR_WIDTH-1:0] ex_rd_addr;
  logic [INFO_WIDTH-1:0] ex_info;

  operand_fetch #(
    .WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .ADDR_WIDTH(ADDR_WIDTH), .INFO_WIDTH(INFO_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_we(id_rd_we), .id_rd_addr(id_rd_addr), .id_info(id_info),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr), .ex_info(ex_info)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic        rd_we;
    logic [4:0]  rd;
    logic [63:0] info;
    logic [31:0] wbv;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } wb_t;

  exp_t        exp_q[$];
  wb_t         wb_q[$];
  logic [31:0] regs[32];
  logic [31:0] arch[32];
  logic [31:0] busy_m = '0;
  int          pend[32];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_wb_cyc = 0;
  int          wb_delay = 1;
  bit          rand_wb = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Write-first regfile with one-cycle read; unread cycles return noise.
  always @(posedge clk) begin
    if (rs1_en) rs1_data <= (wb_en && wb_addr == rs1_addr && wb_addr != 0) ? wb_data : regs[rs1_addr];
    else        rs1_data <= $urandom;
    if (rs2_en) rs2_data <= (wb_en && wb_addr == rs2_addr && wb_addr != 0) ? wb_data : regs[rs2_addr];
    else        rs2_data <= $urandom;
    if (wb_en && wb_addr != 0) regs[wb_addr] <= wb_data;
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ex_ready = 1'b1;
      1:       ex_ready = ($urandom_range(0, 3) != 0);
      default: ex_ready = 1'b0;
    endcase
  end

  wb_t wq;
  always @(posedge clk) begin
    #1;
    wb_en = 1'b0;
    if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
      wq      = wb_q.pop_front();
      wb_en   = 1'b1;
      wb_addr = wq.addr;
      wb_data = wq.data;
    end
  end

  exp_t        me;
  wb_t         mw;
  logic [31:0] nb;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy_m = '0;
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      chk("busy_vector", dut.u_sb.busy, busy_m);
      nb = busy_m;
      if (ex_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ex_valid actual=1 required=0");
        end else begin
          me = exp_q[0];
          chk("ex_rs1_data", ex_rs1_data, me.rs1v);
          chk("ex_rs2_data", ex_rs2_data, me.rs2v);
          chk("ex_rd_we", ex_rd_we, me.rd_we);
          chk("ex_rd_addr", ex_rd_addr, me.rd);
          chk("ex_info", ex_info, me.info);
          if (ex_ready) begin
            void'(exp_q.pop_front());
            if (me.rd_we && me.rd != 0) begin
              mw.addr = me.rd;
              mw.data = me.wbv;
              mw.due  = cyc + 1 + (rand_wb ? $urandom_range(0, 3) : wb_delay);
              wb_q.push_back(mw);
            end
          end else if (flush) begin
            void'(exp_q.pop_front());
            if (me.rd_we && me.rd != 0) pend[me.rd]--;
          end
        end
      end
      if (wb_en && wb_addr != 0) begin
        nb[wb_addr] = 1'b0;
        last_wb_cyc = cyc;
        if (WB_GAP == 0) pend[wb_addr]--;
      end
      if (ex_valid && ex_ready && exp_q.size() >= 0 && me.rd_we && me.rd != 0) nb[me.rd] = 1'b1;
      busy_m = nb;
      if (id_valid && id_ready) begin
        if (id_rs1_use && id_rs1_addr != 0) chk("hazard_rs1", pend[id_rs1_addr], 0);
        if (id_rs2_use && id_rs2_addr != 0) chk("hazard_rs2", pend[id_rs2_addr], 0);
        if (id_rd_we && id_rd_addr != 0) begin
          chk("hazard_rd", pend[id_rd_addr], 0);
          pend[id_rd_addr]++;
        end
      end
      if (WB_GAP != 0 && wb_en && wb_addr != 0) pend[wb_addr]--;
    end
  end

  task automatic issue(input logic u1, input logic [4:0] a1, input logic u2, input logic [4:0] a2,
                       input logic we, input logic [4:0] rd, input logic [31:0] wbv, output int acc);
    exp_t e;
    int   n;
    bit   got;
    e.rs1v  = u1 ? arch[a1] : 32'h0;
    e.rs2v  = u2 ? arch[a2] : 32'h0;
    e.rd_we = we;
    e.rd    = rd;
    e.info  = {$urandom, $urandom};
    e.wbv   = wbv;
    exp_q.push_back(e);
    if (we && rd != 0) arch[rd] = wbv;
    id_valid = 1'b1; id_rs1_use = u1; id_rs1_addr = a1; id_rs2_use = u2; id_rs2_addr = a2;
    id_rd_we = we; id_rd_addr = rd; id_info = e.info;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (id_ready) got = 1'b1;
    end
    acc = cyc;
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=stalled required=accept");
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || wb_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int acc[4];
  int a, b;
  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'h0 : $urandom;
      arch[i] = regs[i];
      pend[i] = 0;
    end
    id_valid = 1'b1; id_rs1_use = 1'b1; id_rs2_use = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_id_ready", id_ready, 0);
    chk("rst_rs1_en", rs1_en, 0);
    @(posedge clk); #1;
    rst = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_rs1_data", ex_rs1_data, 0);
    chk("rst_ex_rs2_data", ex_rs2_data, 0);
    chk("rst_ex_rd_we", ex_rd_we, 0);
    chk("rst_ex_info", ex_info, 0);
    chk("rst_rs1_addr", rs1_addr, 0);
    @(posedge clk); #1;

    // independent stream at full rate
    for (int i = 0; i < 4; i++) issue(1'b1, 5'(i + 1), 1'b0, 5'd0, 1'b1, 5'(i + 1), $urandom, acc[i]);
    for (int i = 1; i < 4; i++) chk("stream_back_to_back", acc[i] - acc[0], i);
    drain();

    // RAW on x5
    wb_delay = 2;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, a);
    issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, b);
    chk("raw_issue_cycle", b - last_wb_cyc, WB_GAP);
    drain();

    // backpressure with changing read data
    rdy_mode = 2;
    issue(1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 5'd0, 32'h0, a);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_id_ready", id_ready, 0);
      chk("bp_ex_valid", ex_valid, 1);
    end
    drain();

    // x0 never stalls
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, $urandom, a);
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, b);
    chk("x0_no_stall", b - a, 1);
    @(negedge clk);
    chk("x0_busy_zero", dut.u_sb.busy, 0);
    drain();

    // WAW on x7, then read it back
    wb_delay = 2;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, $urandom, a);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, $urandom, b);
    chk("waw_issue_cycle", b - last_wb_cyc, WB_GAP);
    issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, a);
    drain();

    // flush while held
    rdy_mode = 2;
    saved = arch[9];
    issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd9, $urandom, a);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_id_ready", id_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_busy", dut.u_sb.busy, 0);
    arch[9] = saved;
    drain();

    // reset while held
    rdy_mode = 2;
    issue(1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 5'd13, 32'h0, a);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; id_valid = 1'b1; id_rs1_use = 1'b1; id_rs2_use = 1'b1;
    @(negedge clk);
    chk("rstmid_id_ready", id_ready, 0);
    chk("rstmid_rs1_en", rs1_en, 0);
    @(posedge clk); #1;
    rst = 1'b0; id_valid = 1'b0; rdy_mode = 0;
    @(negedge clk);
    chk("rstmid_ex_valid", ex_valid, 0);
    chk("rstmid_ex_rs1_data", ex_rs1_data, 0);
    chk("rstmid_ex_rs2_data", ex_rs2_data, 0);
    chk("rstmid_ex_rd_addr", ex_rd_addr, 0);
    chk("rstmid_ex_info", ex_info, 0);
    chk("rstmid_rs1_addr", rs1_addr, 0);
    chk("rstmid_rs2_addr", rs2_addr, 0);
    @(posedge clk); #1;

    // randomized traffic on a small register window to provoke hazards
    rdy_mode = 1;
    rand_wb = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, a);
    end
    drain();
    rand_wb = 1'b0;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
